vga_pixel_fetch: RTL and testbench

Downstream companion of the VGA sync generator. It consumes the registered sync and blank stream, and tracks the active pixel position from the blank edges. It issues framebuffer read requests in raster order, then re-aligns the returned pixel data with delayed copies of sync and blank so that colour and timing reach the DAC pins on the same cycle. During blanking it drives black. It flags geometry errors when the incoming timing does not match the configured resolution.

---
 rtl/vga_pixel_fetch.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Raster-order framebuffer fetch that lines up returned pixels with delayed sync/blank for the DAC.
// Latency: fixed RD_LAT+2 cycles from in_* to out_* (colour, sync and blank all leave on the same cycle).
// Backpressure: none; one read per visible cycle, the memory must answer exactly RD_LAT cycles later.
//
// Ports:
//   in_vga_clk / in_reset         pixel clock, synchronous active-high reset
//   in_blank_n/h_sync/v_sync      timing stream from the sync generator (syncs active low)
//   out_rd_en / out_rd_addr       framebuffer read strobe and word address
//   in_rd_data                    {R,G,B} returned RD_LAT cycles after a read
//   out_r/g/b, out_*_sync, out_blank_n   aligned DAC outputs
//   out_frame_start               pulse on each v_sync falling edge (not delayed)
//   out_geom_err                  sticky: timing does not match H_ACTIVE x V_ACTIVE
//
// Build option: define VGA_PIXEL_DOUBLE_EN for 2x pixel/line doubling from a
// (H_ACTIVE/2) x (V_ACTIVE/2) framebuffer.

module vga_pixel_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = 19,
  parameter int COL_W    = 4
) (
  input  logic                 in_vga_clk,
  input  logic                 in_reset,
  input  logic                 in_blank_n,
  input  logic                 in_h_sync,
  input  logic                 in_v_sync,
  output logic                 out_rd_en,
  output logic [ADDR_W-1:0]    out_rd_addr,
  input  logic [3*COL_W-1:0]   in_rd_data,
  output logic [COL_W-1:0]     out_r,
  output logic [COL_W-1:0]     out_g,
  output logic [COL_W-1:0]     out_b,
  output logic                 out_h_sync,
  output logic                 out_v_sync,
  output logic                 out_blank_n,
  output logic                 out_frame_start,
  output logic                 out_geom_err
);

  localparam int DLY = RD_LAT + 2;
  localparam int XW  = $clog2(H_ACTIVE + 1);
  localparam int YW  = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);
`ifdef VGA_PIXEL_DOUBLE_EN
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_ACTIVE
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   line_base_q, line_base_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                frame_start_q, frame_start_d;
  logic                geom_err_q, geom_err_d;

  // Stage 0 of each pipe doubles as the d1 copy used for edge detection.
  logic [DLY-1:0]      blank_pipe_q, blank_pipe_d;
  logic [DLY-1:0]      hs_pipe_q, hs_pipe_d;
  logic [DLY-1:0]      vs_pipe_q, vs_pipe_d;

  // Tracks which in-flight memory slots carry a real read.
  logic [RD_LAT-1:0]   fetch_pipe_q, fetch_pipe_d;
  logic [3*COL_W-1:0]  rgb_q, rgb_d;

  logic                vs_fall;
  logic                bl_rise;
  logic                bl_fall;
  logic [ADDR_W-1:0]   pix_off;

  assign vs_fall = ~in_v_sync & vs_pipe_q[0];
  assign bl_rise = in_blank_n & ~blank_pipe_q[0];
  assign bl_fall = ~in_blank_n & blank_pipe_q[0];

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    line_base_d   = line_base_q;
    geom_err_d    = geom_err_q;
    frame_start_d = vs_fall;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    pix_off       = '0;

    // x counts visible cycles of the current line and saturates at H_ACTIVE,
    // so at a blank fall it holds the number of pixels the line carried.
    if (state_q == S_ACTIVE && blank_pipe_q[0] && x_q < X_MAX) begin
      x_d = x_q + XW'(1);
    end

    // v_sync fall has priority over any simultaneous blank edge.
    if (vs_fall) begin
      state_d     = S_WAIT_LINE;
      y_d         = '0;
      line_base_d = '0;
    end else begin
      unique case (state_q)
        S_WAIT_LINE: begin
          if (bl_rise) begin
            state_d = S_ACTIVE;
            x_d     = '0;
            if (y_q >= Y_MAX) begin
              geom_err_d = 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (bl_fall) begin
            state_d = S_WAIT_LINE;
            if (x_d < X_MAX) begin
              geom_err_d = 1'b1;
            end
            if (y_q < Y_MAX) begin
              y_d = y_q + YW'(1);
            end
`ifdef VGA_PIXEL_DOUBLE_EN
            // Each framebuffer row is shown twice; move on after the odd copy.
            if (y_q[0]) begin
              line_base_d = line_base_q + LINE_STEP;
            end
`else
            line_base_d = line_base_q + LINE_STEP;
`endif
          end
        end
        default: ;
      endcase
    end

`ifdef VGA_PIXEL_DOUBLE_EN
    pix_off = ADDR_W'(x_d >> 1);
`else
    pix_off = ADDR_W'(x_d);
`endif

    // Issue decided from next-cycle state so the strobe leaves a flop one cycle
    // after the visible input, with the matching address.
    if (state_d == S_ACTIVE && in_blank_n) begin
      if (x_d < X_MAX && y_d < Y_MAX) begin
        rd_en_d   = 1'b1;
        rd_addr_d = line_base_d + pix_off;
      end else begin
        geom_err_d = 1'b1;
      end
    end

    blank_pipe_d = {blank_pipe_q[DLY-2:0], in_blank_n};
    hs_pipe_d    = {hs_pipe_q[DLY-2:0], in_h_sync};
    vs_pipe_d    = {vs_pipe_q[DLY-2:0], in_v_sync};

    fetch_pipe_d    = '0;
    fetch_pipe_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) begin
      fetch_pipe_d[i] = fetch_pipe_q[i-1];
    end

    // Data on the bus now belongs to the input sampled RD_LAT+1 cycles ago,
    // whose blank copy sits in stage RD_LAT of the delay pipe.
    rgb_d = '0;
    if (fetch_pipe_q[RD_LAT-1] && blank_pipe_q[DLY-2]) begin
      rgb_d = in_rd_data;
    end
  end

  always_ff @(posedge in_vga_clk) begin
    if (in_reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      line_base_q   <= '0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      frame_start_q <= 1'b0;
      geom_err_q    <= 1'b0;
      blank_pipe_q  <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      fetch_pipe_q  <= '0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_base_q   <= line_base_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      frame_start_q <= frame_start_d;
      geom_err_q    <= geom_err_d;
      blank_pipe_q  <= blank_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      fetch_pipe_q  <= fetch_pipe_d;
      rgb_q         <= rgb_d;
    end
  end

  assign out_rd_en       = rd_en_q;
  assign out_rd_addr     = rd_addr_q;
  assign out_frame_start = frame_start_q;
  assign out_geom_err    = geom_err_q;
  assign out_blank_n     = blank_pipe_q[DLY-1];
  assign out_h_sync      = hs_pipe_q[DLY-1];
  assign out_v_sync      = vs_pipe_q[DLY-1];
  assign out_r           = rgb_q[3*COL_W-1:2*COL_W];
  assign out_g           = rgb_q[2*COL_W-1:COL_W];
  assign out_b           = rgb_q[COL_W-1:0];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
`timescale 1ns/1ps
module tb_vga_pixel_fetch;
  localparam int H   = 16;
  localparam int V   = 6;
  localparam int LAT = 2;
  localparam int AW  = 19;
  localparam int CW  = 4;
  localparam int D   = LAT + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, bl, hs, vs;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [3*CW-1:0] rd_data;
  logic [CW-1:0]   r, g, b;
  logic            o_hs, o_vs, o_bl, fs, err;

  vga_pixel_fetch #(
    .H_ACTIVE(H), .V_ACTIVE(V), .RD_LAT(LAT), .ADDR_W(AW), .COL_W(CW)
  ) dut (
    .in_vga_clk(clk), .in_reset(rst),
    .in_blank_n(bl), .in_h_sync(hs), .in_v_sync(vs),
    .out_rd_en(rd_en), .out_rd_addr(rd_addr), .in_rd_data(rd_data),
    .out_r(r), .out_g(g), .out_b(b),
    .out_h_sync(o_hs), .out_v_sync(o_vs), .out_blank_n(o_bl),
    .out_frame_start(fs), .out_geom_err(err)
  );

  // One record per input cycle: what the outputs owe to that input.
  typedef struct {
    bit          bl, hs, vs, rd, fs, err;
    int unsigned addr;
  } ent_t;

  ent_t        hist [D];      // hist[0] = previous input cycle, hist[D-1] = D cycles ago
  int unsigned memq [$];      // framebuffer return queue, LAT entries deep
  int          tests = 0;
  int          fails = 0;
  int          rd_count = 0;

  // Raster model state
  bit armed, in_line, m_err, p_bl, p_vs;
  int line_n, px;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rst_ent();
    ent_t e;
    e.bl = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rd = 1'b0; e.fs = 1'b0; e.err = 1'b0; e.addr = 0;
    return e;
  endfunction

  function automatic int unsigned pix_addr(input int l, input int p);
`ifdef VGA_PIXEL_DOUBLE_EN
    return (l / 2) * (H / 2) + (p / 2);
`else
    return l * H + p;
`endif
  endfunction

  task automatic model_reset();
    armed = 0; in_line = 0; m_err = 0; p_bl = 0; p_vs = 1; line_n = 0; px = 0;
    for (int i = 0; i < D; i++) hist[i] = rst_ent();
  endtask

  // Frame/line/pixel bookkeeping straight from the timing rules.
  task automatic model(input bit b_, input bit h_, input bit v_, output ent_t e);
    e.bl = b_; e.hs = h_; e.vs = v_; e.rd = 0; e.fs = 0; e.addr = 0;
    if (p_vs && !v_) begin
      armed = 1; in_line = 0; line_n = 0; e.fs = 1;
    end else if (armed && !in_line && b_ && !p_bl) begin
      in_line = 1; px = 0;
    end else if (in_line && !b_ && p_bl) begin
      in_line = 0;
      if (px < H) m_err = 1;
      line_n++;
    end
    if (in_line && b_) begin
      if (px < H && line_n < V) begin
        e.rd = 1; e.addr = pix_addr(line_n, px);
      end else begin
        m_err = 1;
      end
      px++;
    end
    e.err = m_err;
    p_bl = b_; p_vs = v_;
  endtask

  // Check this cycle's outputs, serve memory, apply next inputs, advance one clock.
  task automatic cycle(input bit r_, input bit b_, input bit h_, input bit v_);
    ent_t e;
    logic [3*CW-1:0] exp_rgb;
    check("rd_en", rd_en, hist[0].rd);
    if (hist[0].rd) check("rd_addr", rd_addr, hist[0].addr);
    check("frame_start", fs, hist[0].fs);
    check("geom_err", err, hist[0].err);
    check("blank_n", o_bl, hist[D-1].bl);
    check("h_sync", o_hs, hist[D-1].hs);
    check("v_sync", o_vs, hist[D-1].vs);
    exp_rgb = hist[D-1].rd ? (3*CW)'(hist[D-1].addr) : '0;
    check("rgb", {r, g, b}, exp_rgb);
    if (rd_en === 1'b1) rd_count++;

    rd_data = (3*CW)'(memq.pop_front());
    memq.push_back((rd_en === 1'b1) ? 32'(rd_addr) : $urandom);

    rst = r_; bl = b_; hs = h_; vs = v_;
    if (r_) begin
      model_reset();
    end else begin
      model(b_, h_, v_, e);
      for (int i = D - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = e;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int vis, input bit v_);
    int pre, post;
    pre  = $urandom_range(3, 6);
    post = $urandom_range(2, 5);
    for (int i = 0; i < pre; i++)  cycle(0, 0, (i < 2) ? 1'b0 : 1'b1, v_);
    for (int i = 0; i < vis; i++)  cycle(0, 1, 1, v_);
    for (int i = 0; i < post; i++) cycle(0, 0, 1, v_);
  endtask

  task automatic vblank();
    line(0, 0); line(0, 0); line(0, 1);
  endtask

  initial begin
    rst = 1; bl = 1; hs = 1; vs = 1; rd_data = '0;
    model_reset();
    for (int i = 0; i < LAT; i++) memq.push_back(0);
    @(posedge clk);
    #1;
    // Reset held three cycles in the middle of a visible run
    cycle(1, 1, 1, 1);
    cycle(1, 1, 0, 1);

    // Blank activity before any v_sync must not fetch
    rd_count = 0;
    line(H, 1); line(H, 1);
    check("idle_reads", rd_count, 0);

    // Two clean frames
    for (int f = 0; f < 2; f++) begin
      rd_count = 0;
      vblank();
      for (int l = 0; l < V; l++) line(H, 1);
      line(0, 1);
      check("frame_reads", rd_count, H * V);
      check("clean_err", err, 0);
    end

    // One line too long: overflow pixel is black and the error sticks
    cycle(1, 0, 1, 1);
    vblank();
    line(H, 1); line(H + 1, 1);
    check("ovf_err", err, 1);
    for (int l = 0; l < 3; l++) line(H, 1);
    check("ovf_err_sticky", err, 1);

    // v_sync injected mid-frame restarts addressing at 0
    cycle(1, 0, 1, 1);
    vblank();
    for (int l = 0; l < 3; l++) line(H, 1);
    line(0, 0); line(0, 1);
    line(H, 1); line(H, 1);
    check("inject_err", err, 0);

    // v_sync fall on the same cycle as a blank rise: that line is skipped
    cycle(1, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1);
    rd_count = 0;
    for (int i = 0; i < H; i++) cycle(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    check("simul_reads", rd_count, 0);
    line(H, 1); line(H, 1);
    check("simul_err", err, 0);

    // Short line flags an error
    cycle(1, 0, 1, 1);
    vblank();
    line(H - 3, 1);
    line(0, 1);
    check("short_err", err, 1);

    // Too many visible lines flags an error
    cycle(1, 0, 1, 1);
    vblank();
    for (int l = 0; l < V; l++) line(H, 1);
    check("vfit_err", err, 0);
    line(H, 1);
    check("vover_err", err, 1);

    // Random timing: line lengths around H and occasional v_sync drops
    cycle(1, 0, 1, 1);
    vblank();
    for (int l = 0; l < 40; l++) begin
      line(($urandom_range(0, 3) == 0) ? $urandom_range(0, H + 2) : H,
           ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1);
    end
    line(0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
